// File: rtl/updown_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// updown_sweep_ctrl
//
// Runs N triangular sweeps lo -> hi -> lo on a WIDTH-bit up/down counter that
// this block owns. It reports completion with a one-cycle done pulse and flags
// a rejected start with a one-cycle err pulse. Bounds and the sweep count are
// latched when a start is accepted, so upstream may change them afterwards.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; q holds its last value
// UP    | q counting up towards latched hi
// DOWN  | q counting down towards latched lo; a sweep ends at q == lo
//
// Ports
//   clk            rising-edge clock
//   reset_in       asynchronous, active-high reset
//   start_in       launch request, sampled in IDLE only
//   abort_in       synchronous abort back to IDLE (beats pause)
//   pause_in       freezes q, state and sweep count while high
//   lo_in, hi_in   sweep bounds, latched on an accepted start
//   sweeps_in      number of sweeps N, latched on an accepted start
//   q_out          counter value
//   up_down_out    direction, 0 = up, 1 = down (high exactly in DOWN)
//   busy_out       high in UP or DOWN
//   done_out       one-cycle pulse after the last sweep completes
//   err_out        one-cycle pulse when a start is rejected
//   sweep_cnt_out  completed sweeps in the current or last run
// -----------------------------------------------------------------------------
module updown_sweep_ctrl #(
    parameter int WIDTH   = 4,
    parameter int SWEEP_W = 4
) (
    input  logic               clk,
    input  logic               reset_in,
    input  logic               start_in,
    input  logic               abort_in,
    input  logic               pause_in,
    input  logic [WIDTH-1:0]   lo_in,
    input  logic [WIDTH-1:0]   hi_in,
    input  logic [SWEEP_W-1:0] sweeps_in,
    output logic [WIDTH-1:0]   q_out,
    output logic               up_down_out,
    output logic               busy_out,
    output logic               done_out,
    output logic               err_out,
    output logic [SWEEP_W-1:0] sweep_cnt_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0]   Q_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SWEEP_W-1:0] SW_ONE = {{(SWEEP_W-1){1'b0}}, 1'b1};

    state_t             state;
    logic [WIDTH-1:0]   lo_lat;
    logic [WIDTH-1:0]   hi_lat;
    logic [SWEEP_W-1:0] n_lat;

    logic               start_ok;
    logic               q_at_hi;
    logic               q_above_lo;
    logic [SWEEP_W-1:0] sweep_cnt_nxt;
    logic               last_sweep;

    // A start needs a non-empty range and at least one sweep.
    assign start_ok      = (lo_in < hi_in) && (sweeps_in != '0);

    // >= rather than == keeps the turn-around safe even if q were ever
    // outside the latched range.
    assign q_at_hi       = (q_out >= hi_lat);
    assign q_above_lo    = (q_out > lo_lat);
    assign sweep_cnt_nxt = sweep_cnt_out + SW_ONE;
    assign last_sweep    = (sweep_cnt_nxt == n_lat);

    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            state         <= ST_IDLE;
            q_out         <= '0;
            up_down_out   <= 1'b0;
            busy_out      <= 1'b0;
            done_out      <= 1'b0;
            err_out       <= 1'b0;
            sweep_cnt_out <= '0;
            lo_lat        <= '0;
            hi_lat        <= '0;
            n_lat         <= '0;
        end else begin
            // Both flags are single-cycle pulses.
            done_out <= 1'b0;
            err_out  <= 1'b0;

            if (abort_in) begin
                // q and sweep count are left as they were, for inspection.
                // In IDLE this also swallows any start in the same cycle.
                if (state != ST_IDLE) begin
                    state       <= ST_IDLE;
                    up_down_out <= 1'b0;
                    busy_out    <= 1'b0;
                end
            end else if (!pause_in) begin
                case (state)
                    ST_IDLE: begin
                        if (start_in) begin
                            if (start_ok) begin
                                lo_lat        <= lo_in;
                                hi_lat        <= hi_in;
                                n_lat         <= sweeps_in;
                                q_out         <= lo_in;
                                sweep_cnt_out <= '0;
                                state         <= ST_UP;
                                up_down_out   <= 1'b0;
                                busy_out      <= 1'b1;
                            end else begin
                                err_out <= 1'b1;
                            end
                        end
                    end

                    ST_UP: begin
                        if (q_at_hi) begin
                            // Turn around without dwelling at hi.
                            q_out       <= hi_lat - Q_ONE;
                            state       <= ST_DOWN;
                            up_down_out <= 1'b1;
                        end else begin
                            q_out <= q_out + Q_ONE;
                        end
                    end

                    ST_DOWN: begin
                        if (q_above_lo) begin
                            q_out <= q_out - Q_ONE;
                        end else begin
                            // q sat at lo for one cycle: that sweep is done.
                            sweep_cnt_out <= sweep_cnt_nxt;
                            up_down_out   <= 1'b0;
                            if (last_sweep) begin
                                state    <= ST_IDLE;
                                busy_out <= 1'b0;
                                done_out <= 1'b1;
                            end else begin
                                q_out <= lo_lat + Q_ONE;
                                state <= ST_UP;
                            end
                        end
                    end

                    default: begin
                        state       <= ST_IDLE;
                        up_down_out <= 1'b0;
                        busy_out    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// Directed bench for updown_sweep_ctrl (WIDTH=4, SWEEP_W=4).
// Outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_updown_sweep_ctrl;

    logic       clk;
    logic       reset_in;
    logic       start_in;
    logic       abort_in;
    logic       pause_in;
    logic [3:0] lo_in;
    logic [3:0] hi_in;
    logic [3:0] sweeps_in;
    logic [3:0] q_out;
    logic       up_down_out;
    logic       busy_out;
    logic       done_out;
    logic       err_out;
    logic [3:0] sweep_cnt_out;

    int n_cmp = 0;
    int n_err = 0;

    updown_sweep_ctrl #(.WIDTH(4), .SWEEP_W(4)) dut (
        .clk           (clk),
        .reset_in      (reset_in),
        .start_in      (start_in),
        .abort_in      (abort_in),
        .pause_in      (pause_in),
        .lo_in         (lo_in),
        .hi_in         (hi_in),
        .sweeps_in     (sweeps_in),
        .q_out         (q_out),
        .up_down_out   (up_down_out),
        .busy_out      (busy_out),
        .done_out      (done_out),
        .err_out       (err_out),
        .sweep_cnt_out (sweep_cnt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a start for exactly one edge; returns 1 unit after that edge.
    task automatic do_start(input int lo, input int hi, input int n);
        lo_in     = 4'(lo);
        hi_in     = 4'(hi);
        sweeps_in = 4'(n);
        start_in  = 1'b1;
        step();
        start_in  = 1'b0;
    endtask

    // Full run with a triangle model; optional pause of pause_len cycles
    // inserted right after the sample at step pause_k (-1 = no pause).
    task automatic run_sweep(input int lo, input int hi, input int n,
                             input int pause_k, input int pause_len);
        int d;
        int last;
        int p;
        int qe;
        int de;
        int se;
        d    = hi - lo;
        last = 2 * d * n;
        do_start(lo, hi, n);
        // Latched copies must be the ones in use from here on.
        lo_in     = 4'($urandom);
        hi_in     = 4'($urandom);
        sweeps_in = 4'($urandom);
        for (int k = 0; k <= last; k++) begin
            if (k > 0) step();
            p  = k % (2 * d);
            qe = lo + ((p <= d) ? p : (2 * d - p));
            de = ((p > d) || (p == 0 && k > 0)) ? 1 : 0;
            se = (k == 0) ? 0 : (k - 1) / (2 * d);
            chk("run_q",    32'(q_out),         32'(qe));
            chk("run_dir",  32'(up_down_out),   32'(de));
            chk("run_busy", 32'(busy_out),      32'd1);
            chk("run_scnt", 32'(sweep_cnt_out), 32'(se));
            chk("run_done", 32'(done_out),      32'd0);
            if (k == pause_k) begin
                pause_in = 1'b1;
                for (int j = 0; j < pause_len; j++) begin
                    step();
                    chk("pause_q",    32'(q_out),       32'(qe));
                    chk("pause_dir",  32'(up_down_out), 32'(de));
                    chk("pause_busy", 32'(busy_out),    32'd1);
                    chk("pause_done", 32'(done_out),    32'd0);
                end
                pause_in = 1'b0;
            end
        end
        step();
        chk("end_done", 32'(done_out),      32'd1);
        chk("end_busy", 32'(busy_out),      32'd0);
        chk("end_scnt", 32'(sweep_cnt_out), 32'(n));
        chk("end_q",    32'(q_out),         32'(lo));
        chk("end_dir",  32'(up_down_out),   32'd0);
        step();
        chk("end_done_clr", 32'(done_out), 32'd0);
    endtask

    initial begin
        int qv [5];
        int dv [5];
        int av [7];
        qv = '{1, 2, 3, 2, 1};
        dv = '{0, 0, 0, 1, 1};
        av = '{1, 2, 3, 4, 5, 4, 3};

        reset_in  = 1'b1;
        start_in  = 1'b0;
        abort_in  = 1'b0;
        pause_in  = 1'b0;
        lo_in     = '0;
        hi_in     = '0;
        sweeps_in = '0;
        repeat (2) step();
        reset_in = 1'b0;
        step();
        chk("rst_q",    32'(q_out),         32'd0);
        chk("rst_dir",  32'(up_down_out),   32'd0);
        chk("rst_busy", 32'(busy_out),      32'd0);
        chk("rst_done", 32'(done_out),      32'd0);
        chk("rst_err",  32'(err_out),       32'd0);
        chk("rst_scnt", 32'(sweep_cnt_out), 32'd0);

        // lo=1 hi=3 N=1, hand table; bounds scrambled after start.
        do_start(1, 3, 1);
        lo_in = 4'd7;
        hi_in = 4'd9;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) step();
            chk("t1_q",    32'(q_out),       32'(qv[k]));
            chk("t1_dir",  32'(up_down_out), 32'(dv[k]));
            chk("t1_busy", 32'(busy_out),    32'd1);
            chk("t1_done", 32'(done_out),    32'd0);
        end
        step();
        chk("t1_done5", 32'(done_out),      32'd1);
        chk("t1_busy5", 32'(busy_out),      32'd0);
        chk("t1_scnt",  32'(sweep_cnt_out), 32'd1);
        chk("t1_q5",    32'(q_out),         32'd1);

        // New start in the done cycle: lo=0 hi=1 N=1 -> 0,1,0,done.
        do_start(0, 1, 1);
        chk("t1b_q0",    32'(q_out),         32'd0);
        chk("t1b_busy0", 32'(busy_out),      32'd1);
        chk("t1b_done0", 32'(done_out),      32'd0);
        chk("t1b_scnt0", 32'(sweep_cnt_out), 32'd0);
        step();
        chk("t1b_q1", 32'(q_out), 32'd1);
        step();
        chk("t1b_q2",   32'(q_out),       32'd0);
        chk("t1b_dir2", 32'(up_down_out), 32'd1);
        step();
        chk("t1b_done3", 32'(done_out), 32'd1);
        chk("t1b_busy3", 32'(busy_out), 32'd0);
        step();

        // Full range, no wrap: done after edge 61.
        run_sweep(0, 15, 2, -1, 0);

        // Pause 3 cycles while q=2 in UP: done after edge 8.
        run_sweep(1, 3, 1, 1, 3);

        // Rejected starts: q stays at 1 from the previous run.
        do_start(5, 5, 1);
        chk("err_eq",      32'(err_out),  32'd1);
        chk("err_eq_busy", 32'(busy_out), 32'd0);
        chk("err_eq_q",    32'(q_out),    32'd1);
        step();
        chk("err_eq_clr",  32'(err_out),  32'd0);
        do_start(2, 9, 0);
        chk("err_n0",      32'(err_out),  32'd1);
        chk("err_n0_busy", 32'(busy_out), 32'd0);
        chk("err_n0_q",    32'(q_out),    32'd1);
        do_start(9, 2, 3);
        chk("err_gt",      32'(err_out),  32'd1);
        chk("err_gt_q",    32'(q_out),    32'd1);
        step();

        // Abort in IDLE swallows a valid start.
        abort_in = 1'b1;
        do_start(2, 6, 1);
        abort_in = 1'b0;
        chk("abidle_busy", 32'(busy_out), 32'd0);
        chk("abidle_err",  32'(err_out),  32'd0);
        chk("abidle_q",    32'(q_out),    32'd1);

        // lo=1 hi=5 N=3, starts while busy ignored, abort at q=3 in DOWN.
        do_start(1, 5, 3);
        for (int k = 0; k < 7; k++) begin
            if (k > 0) step();
            chk("ab_q",    32'(q_out),    32'(av[k]));
            chk("ab_busy", 32'(busy_out), 32'd1);
            chk("ab_err",  32'(err_out),  32'd0);
            if (k == 1) begin
                lo_in     = 4'd0;
                hi_in     = 4'd0;
                sweeps_in = 4'd0;
                start_in  = 1'b1;
            end
            if (k == 3) start_in = 1'b0;
        end
        chk("ab_dir6", 32'(up_down_out), 32'd1);
        abort_in = 1'b1;
        step();
        abort_in = 1'b0;
        chk("ab_busy_post", 32'(busy_out),      32'd0);
        chk("ab_q_post",    32'(q_out),         32'd3);
        chk("ab_dir_post",  32'(up_down_out),   32'd0);
        chk("ab_scnt_post", 32'(sweep_cnt_out), 32'd0);
        chk("ab_done_post", 32'(done_out),      32'd0);
        step();
        chk("ab_done_late", 32'(done_out), 32'd0);
        chk("ab_q_late",    32'(q_out),    32'd3);

        // Async reset mid-sweep: lo=2 hi=4 N=2, after edge 7 q=3, DOWN, scnt=1.
        do_start(2, 4, 2);
        repeat (7) step();
        chk("ar_q_pre",    32'(q_out),         32'd3);
        chk("ar_dir_pre",  32'(up_down_out),   32'd1);
        chk("ar_scnt_pre", 32'(sweep_cnt_out), 32'd1);
        #2;
        reset_in = 1'b1;
        #1;
        chk("ar_q",    32'(q_out),         32'd0);
        chk("ar_dir",  32'(up_down_out),   32'd0);
        chk("ar_busy", 32'(busy_out),      32'd0);
        chk("ar_scnt", 32'(sweep_cnt_out), 32'd0);
        step();
        reset_in = 1'b0;
        step();
        chk("ar_idle", 32'(busy_out), 32'd0);

        run_sweep(1, 3, 1, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
